path_replayer: RTL and testbench

- Reader end of the 2-bit direction queue: drains direction codes one at a time and replays them as a handshaked move stream.
- Tracks the current (x, y) grid position starting from a loaded origin, and flags any move that would leave the grid.
- Sits between the path queue and the movement/display logic that consumes one step at a time.

---
 rtl/path_pkg.sv | 21 ++
 rtl/step_calc.sv | 35 +++
 rtl/path_replayer.sv | 125 ++++++++++++
 tb/tb_path_replayer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/path_pkg.sv
// Shared types for the path queue reader/writer: direction codes and replay states.
package path_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_ISSUE,
    ST_DONE
  } state_t;

  localparam int STEP_CNT_W = 16;

endpackage

// File: rtl/step_calc.sv
// Combinational single-step move: next position plus out-of-bounds flag.
// The position is left untouched when the move would leave the grid.
module step_calc
  import path_pkg::*;
#(
  parameter int COORD_W = 4,
  parameter int GRID_W  = 16,
  parameter int GRID_H  = 16
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  dir_t               dir,
  output logic [COORD_W-1:0] nx,
  output logic [COORD_W-1:0] ny,
  output logic               oob
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H - 1);
  localparam logic [COORD_W-1:0] ONE   = COORD_W'(1);

  always_comb begin
    nx  = x;
    ny  = y;
    oob = 1'b0;
    unique case (dir)
      DIR_UP:    if (y == '0)    oob = 1'b1; else ny = y - ONE;
      DIR_RIGHT: if (x >= X_MAX) oob = 1'b1; else nx = x + ONE;
      DIR_DOWN:  if (y >= Y_MAX) oob = 1'b1; else ny = y + ONE;
      DIR_LEFT:  if (x == '0)    oob = 1'b1; else nx = x - ONE;
      default:   oob = 1'b0;
    endcase
  end

endmodule

// File: rtl/path_replayer.sv
// Drains 2-bit direction codes from the path queue and replays them as a
// handshaked move stream while tracking (x, y). Optional: PATH_REPLAYER_STEP_COUNT_EN.
module path_replayer
  import path_pkg::*;
#(
  parameter int COORD_W = 4,
  parameter int GRID_W  = 16,
  parameter int GRID_H  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] start_x,
  input  logic [COORD_W-1:0] start_y,
  input  logic               q_empty,
  input  logic [1:0]         q_data,
  output logic               q_dequeue,
  output logic               mv_valid,
  input  logic               mv_ready,
  output logic [1:0]         mv_dir,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y,
  output logic               busy,
  output logic               done,
`ifdef PATH_REPLAYER_STEP_COUNT_EN
  output logic [STEP_CNT_W-1:0] step_count,
`endif
  output logic               err
);

  state_t               state_q, state_d;
  dir_t                 dir_q, dir_d;
  logic [COORD_W-1:0]   cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic                 done_q, done_d, err_q, err_d;
  logic [STEP_CNT_W-1:0] step_q, step_d;
  logic [COORD_W-1:0]   nx, ny;
  logic                 oob;

  step_calc #(.COORD_W(COORD_W), .GRID_W(GRID_W), .GRID_H(GRID_H)) u_step (
    .x(cur_x_q), .y(cur_y_q), .dir(dir_q), .nx(nx), .ny(ny), .oob(oob)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    done_d  = done_q;
    err_d   = err_q;
    step_d  = step_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          cur_x_d = start_x;
          cur_y_d = start_y;
          done_d  = 1'b0;
          err_d   = 1'b0;
          step_d  = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (q_empty) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_LOAD;
        end
      end
      // Queue output is registered, so the popped code is only valid here.
      ST_LOAD: begin
        dir_d   = dir_t'(q_data);
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (mv_ready) begin
          if (oob) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            cur_x_d = nx;
            cur_y_d = ny;
            if (step_q != '1) step_d = step_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      cur_x_q <= '0;
      cur_y_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      done_q  <= done_d;
      err_q   <= err_d;
      step_q  <= step_d;
    end
  end

  assign q_dequeue = (state_q == ST_FETCH) && !q_empty;
  assign mv_valid  = (state_q == ST_ISSUE);
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_LOAD) || (state_q == ST_ISSUE);
  assign mv_dir    = dir_q;
  assign cur_x     = cur_x_q;
  assign cur_y     = cur_y_q;
  assign done      = done_q;
  assign err       = err_q;
`ifdef PATH_REPLAYER_STEP_COUNT_EN
  assign step_count = step_q;
`endif

endmodule

// File: tb/tb_path_replayer.sv
// Scoreboarded bench for path_replayer: a queue model feeds the DUT, a grid-walk
// reference predicts every move, and a monitor checks each handshake.
module tb_path_replayer;

  logic       clk = 1'b0;
  logic       rst, start, mv_ready;
  logic [3:0] start_x, start_y;
  logic       q_empty = 1'b1;
  logic [1:0] q_data = 2'b00;
  logic       q_dequeue, mv_valid, busy, done, err;
  logic [1:0] mv_dir;
  logic [3:0] cur_x, cur_y;
`ifdef PATH_REPLAYER_STEP_COUNT_EN
  logic [15:0] step_count;
`endif

  path_replayer dut (
    .clk(clk), .rst(rst), .start(start), .start_x(start_x), .start_y(start_y),
    .q_empty(q_empty), .q_data(q_data), .q_dequeue(q_dequeue),
    .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_dir(mv_dir),
    .cur_x(cur_x), .cur_y(cur_y), .busy(busy), .done(done),
`ifdef PATH_REPLAYER_STEP_COUNT_EN
    .step_count(step_count),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] dir;
    int         x;
    int         y;
  } exp_t;

  logic [1:0] fifo[$];
  exp_t       exp_q[$];
  int         n_chk = 0, n_fail = 0, hs_cnt = 0, deq_cnt = 0;

  task automatic check(input string name, input int act, input int want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  // Path queue model: registered output, one pop per dequeue.
  always @(posedge clk) begin
    if (q_dequeue && fifo.size() > 0) q_data <= fifo.pop_front();
    q_empty <= (fifo.size() == 0);
  end

  logic       prev_stall = 1'b0;
  logic [1:0] prev_dir = 2'b00;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (q_dequeue) begin
        deq_cnt++;
        check("deq_while_empty", int'(q_empty), 0);
      end
      if (prev_stall && mv_valid) check("dir_stable", int'(mv_dir), int'(prev_dir));
      if (mv_valid && mv_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_move: got dir %0d at (%0d,%0d), expected none", mv_dir, cur_x, cur_y);
        end else begin
          e = exp_q.pop_front();
          check("move_dir", int'(mv_dir), int'(e.dir));
          check("move_x", int'(cur_x), e.x);
          check("move_y", int'(cur_y), e.y);
        end
      end
      prev_stall = mv_valid && !mv_ready;
      prev_dir   = mv_dir;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // mode 0: ready high, 1: random ready, 2: ready low for 5 cycles of each offer
  task automatic run(input int ox, input int oy, input int mode, input bit poke);
    int x, y, nx, ny, nok, ndeq, left, exp_cyc, hs0, deq0, cyc, cnt;
    bit e;
    logic [1:0] d;
    x = ox; y = oy; e = 0; nok = 0; ndeq = 0;
    for (int i = 0; i < fifo.size(); i++) begin
      d = fifo[i];
      ndeq++;
      exp_q.push_back('{d, x, y});
      nx = x; ny = y;
      case (d)
        2'd0: ny = y - 1;
        2'd1: nx = x + 1;
        2'd2: ny = y + 1;
        default: nx = x - 1;
      endcase
      if (nx < 0 || nx >= 16 || ny < 0 || ny >= 16) begin
        e = 1;
        break;
      end
      x = nx; y = ny; nok++;
    end
    left    = fifo.size() - ndeq;
    exp_cyc = e ? 3 * ndeq + 1 : 3 * ndeq + 2;
    hs0 = hs_cnt; deq0 = deq_cnt;
    @(posedge clk); #1;
    start = 1'b1; start_x = 4'(ox); start_y = 4'(oy);
    mv_ready = (mode == 0);
    cyc = 0; cnt = 0;
    while (cyc < 400) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (poke && cyc == 4) begin
        start = 1'b1; start_x = 4'(ox) ^ 4'hF; start_y = 4'(oy) ^ 4'h5;
      end
      if (mode == 1) mv_ready = 1'($urandom_range(0, 1));
      else if (mode == 2) begin
        if (!mv_valid) begin cnt = 0; mv_ready = 1'b0; end
        else begin mv_ready = (cnt >= 5); cnt++; end
      end
      if (done) break;
    end
    mv_ready = 1'b0;
    if (mode == 0) check("cycles_to_done", cyc, exp_cyc);
    check("done", int'(done), 1);
    check("err", int'(err), int'(e));
    check("busy_after", int'(busy), 0);
    check("final_x", int'(cur_x), x);
    check("final_y", int'(cur_y), y);
    check("handshakes", hs_cnt - hs0, ndeq);
    check("dequeues", deq_cnt - deq0, ndeq);
    check("moves_left_unseen", exp_q.size(), 0);
    check("queue_left", fifo.size(), left);
`ifdef PATH_REPLAYER_STEP_COUNT_EN
    check("step_count", int'(step_count), nok);
`endif
    exp_q.delete();
    fifo.delete();
  endtask

  initial begin
    int cyc;
    rst = 1'b0; start = 1'b0; mv_ready = 1'b0; start_x = '0; start_y = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cur_x", int'(cur_x), 0);
    check("rst_cur_y", int'(cur_y), 0);
    check("rst_mv_dir", int'(mv_dir), 0);
    check("rst_q_dequeue", int'(q_dequeue), 0);
    check("rst_mv_valid", int'(mv_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b1;

    fifo = '{2'd1, 2'd1, 2'd2}; run(2, 3, 0, 0);
    run(5, 5, 0, 0);
    fifo = '{2'd3}; run(0, 7, 0, 0);
    fifo = '{2'd0, 2'd1}; run(6, 9, 2, 0);
    fifo = '{2'd1}; run(15, 4, 0, 0);
    fifo = '{2'd0, 2'd1}; run(4, 0, 0, 0);
    fifo = '{2'd2, 2'd2}; run(3, 14, 1, 0);
    fifo = '{2'd1, 2'd2, 2'd1}; run(3, 3, 0, 1);

    // Reset in the middle of an offered move, then resume from a new origin.
    fifo = '{2'd0, 2'd1, 2'd2};
    @(posedge clk); #1;
    start = 1'b1; start_x = 4'd5; start_y = 4'd5; mv_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!mv_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check("reached_issue", int'(mv_valid), 1);
    #2 rst = 1'b0;
    #1;
    check("arst_mv_valid", int'(mv_valid), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_cur_x", int'(cur_x), 0);
    check("arst_cur_y", int'(cur_y), 0);
    check("arst_mv_dir", int'(mv_dir), 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    run(1, 1, 0, 0);

    for (int i = 0; i < 20; i++) begin
      int len;
      len = $urandom_range(0, 6);
      for (int j = 0; j < len; j++) fifo.push_back(2'($urandom_range(0, 3)));
      run($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 2), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
